// File: rtl/shift_pkg.sv
// Shared opcodes, controller state encoding and effective-count helper for shift_seq_ctrl.
package shift_pkg;

    localparam logic [2:0] OP_LSR = 3'd0;
    localparam logic [2:0] OP_ASR = 3'd1;
    localparam logic [2:0] OP_LSL = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

    // Shifts saturate at the operand width; rotates wrap modulo the width.
    function automatic int unsigned eff_count(input logic [2:0] op,
                                              input int unsigned amt,
                                              input int unsigned width);
        int unsigned n;
        case (op)
            OP_LSR, OP_ASR, OP_LSL: n = (amt > width) ? width : amt;
            OP_ROR, OP_ROL:         n = amt % width;
            default:                n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next datapath value and the bit that leaves it.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bit_o
);

    always_comb begin
        d_o   = d_i;
        bit_o = 1'b0;
        case (op_i)
            OP_LSR: begin
                d_o   = {1'b0, d_i[WIDTH-1:1]};
                bit_o = d_i[0];
            end
            OP_ASR: begin
                d_o   = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
                bit_o = d_i[0];
            end
            OP_LSL: begin
                d_o   = {d_i[WIDTH-2:0], 1'b0};
                bit_o = d_i[WIDTH-1];
            end
            OP_ROR: begin
                d_o   = {d_i[0], d_i[WIDTH-1:1]};
                bit_o = d_i[0];
            end
            OP_ROL: begin
                d_o   = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
                bit_o = d_i[WIDTH-1];
            end
            default: begin
                d_o   = d_i;
                bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle serial shift/rotate sequencer: one bit step per clock, valid/ready on both sides.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [CNT_W-1:0]   eff_cnt;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    assign eff_cnt = CNT_W'(eff_count(in_op, 32'(in_amt), WIDTH));

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .d_i   (data_q),
        .d_o   (step_data),
        .bit_o (step_bit)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = in_op;
                    cnt_d   = eff_cnt;
                    carry_d = 1'b0;
                    err_d   = !op_legal(in_op);
                    state_d = (eff_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d  = step_data;
                carry_d = step_bit;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            op_q        <= OP_LSR;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_zero  = ~|data_q;
    assign out_carry = carry_q;
    assign out_err   = err_q;

endmodule
